// File: rtl/sync_fifo.sv
// ============================================================================
// sync_fifo : single-clock first-word-fall-through FIFO (2**ADDR_SIZE entries)
// Rev 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_SIZE  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_inc,
    input  logic [DATA_WIDTH-1:0] w_data,
    output logic                  w_full,
    input  logic                  r_inc,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_empty
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_SIZE:0]    wptr;
    logic [ADDR_SIZE:0]    rptr;
    logic                  do_write;
    logic                  do_read;

    assign do_write = w_inc && !w_full;
    assign do_read  = r_inc && !r_empty;
    assign r_empty  = (wptr == rptr);
    // Extra pointer MSB distinguishes full from empty when the addresses match.
    assign w_full   = (wptr[ADDR_SIZE] != rptr[ADDR_SIZE]) &&
                      (wptr[ADDR_SIZE-1:0] == rptr[ADDR_SIZE-1:0]);
    assign r_data   = mem[rptr[ADDR_SIZE-1:0]];

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wptr[ADDR_SIZE-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_write) begin
                wptr <= wptr + (ADDR_SIZE+1)'(1);
            end
            if (do_read) begin
                rptr <= rptr + (ADDR_SIZE+1)'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_word_packer.sv
// ============================================================================
// fifo_word_packer : packs BYTES FIFO entries little-endian into one output
// word on a valid/ready port; flush emits a partial word. Rev 1.0
// ============================================================================
`default_nettype none

module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int BYTES      = 4,
    localparam int CW        = $clog2(BYTES + 1)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        f_empty,
    input  logic [DATA_WIDTH-1:0]       f_data,
    output logic                        f_inc,
    input  logic                        flush,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [DATA_WIDTH*BYTES-1:0] m_data,
    output logic [CW-1:0]               m_count
);

    localparam int             IW        = $clog2(BYTES);
    localparam int             WW        = DATA_WIDTH * BYTES;
    localparam logic [IW-1:0]  LAST_LANE = IW'(BYTES - 1);

    logic [WW-1:0] acc;
    logic [WW-1:0] acc_filled;
    logic [IW-1:0] idx;
    logic          flush_pending;
    logic          out_free;
    logic          last_pop;
    logic          flush_emit;

    assign out_free   = !m_valid || m_ready;
    // The top lane may only pop when the output register can take the word.
    assign f_inc      = rst_n && !f_empty && !flush_pending &&
                        !(idx == LAST_LANE && !out_free);
    assign last_pop   = f_inc && (idx == LAST_LANE);
    assign flush_emit = flush_pending && (idx != '0) && out_free;

    always_comb begin
        acc_filled = acc;
        acc_filled[idx*DATA_WIDTH +: DATA_WIDTH] = f_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc           <= '0;
            idx           <= '0;
            flush_pending <= 1'b0;
        end else begin
            if (last_pop || flush_emit) begin
                acc <= '0;
                idx <= '0;
            end else if (f_inc) begin
                acc <= acc_filled;
                idx <= idx + IW'(1);
            end
            // Set wins over clear so a held flush keeps re-arming.
            if (flush) begin
                flush_pending <= 1'b1;
            end else if (flush_pending && (idx == '0 || out_free)) begin
                flush_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
        end else if (last_pop) begin
            m_valid <= 1'b1;
            m_data  <= acc_filled;
            m_count <= CW'(BYTES);
        end else if (flush_emit) begin
            m_valid <= 1'b1;
            m_data  <= acc;
            m_count <= CW'(idx);
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_word_packer.sv
// ============================================================================
// tb_fifo_word_packer : directed bench, sync_fifo feeding fifo_word_packer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_rst_n;
    logic        w_inc;
    logic [7:0]  w_data;
    logic        w_full;
    logic        f_inc;
    logic [7:0]  f_data;
    logic        f_empty;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  m_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DATA_WIDTH(8), .ADDR_SIZE(4)) u_fifo (
        .clk     (clk),
        .rst_n   (fifo_rst_n),
        .w_inc   (w_inc),
        .w_data  (w_data),
        .w_full  (w_full),
        .r_inc   (f_inc),
        .r_data  (f_data),
        .r_empty (f_empty)
    );

    fifo_word_packer #(.DATA_WIDTH(8), .BYTES(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .f_empty (f_empty),
        .f_data  (f_data),
        .f_inc   (f_inc),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_count (m_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        w_data = b;
        w_inc  = 1'b1;
        tick();
        w_inc  = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (!m_valid && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 64'(m_valid), 64'd1);
    endtask

    initial begin
        int           finc_cnt;
        int           finc_run;
        int           finc_max;
        int           nwords;
        int           wcycle [4];
        logic [31:0]  words  [4];
        logic [31:0]  exp_w;
        int           quiet;

        rst_n      = 1'b0;
        fifo_rst_n = 1'b0;
        w_inc      = 1'b0;
        w_data     = '0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        repeat (3) tick();
        chk("rst_f_inc", 64'(f_inc), 64'd0);
        rst_n      = 1'b1;
        fifo_rst_n = 1'b1;
        tick();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_count", 64'(m_count), 64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_f_inc_empty", 64'(f_inc), 64'd0);

        // Single word
        m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_valid("w1_valid", 10);
        chk("w1_data",  64'(m_data),  64'h44332211);
        chk("w1_count", 64'(m_count), 64'd4);
        chk("w1_fifo_empty", 64'(f_empty), 64'd1);
        tick();
        chk("w1_one_cycle", 64'(m_valid), 64'd0);

        // Streaming 16 bytes
        finc_cnt = 0; finc_run = 0; finc_max = 0; nwords = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 16) begin
                w_data = 8'(c);
                w_inc  = 1'b1;
            end else begin
                w_inc  = 1'b0;
            end
            tick();
            if (f_inc) begin
                finc_cnt++;
                finc_run++;
                if (finc_run > finc_max) finc_max = finc_run;
            end else begin
                finc_run = 0;
            end
            if (m_valid && nwords < 4) begin
                words[nwords]  = m_data;
                wcycle[nwords] = c;
                nwords++;
            end
        end
        w_inc = 1'b0;
        chk("stream_finc_total", 64'(finc_cnt), 64'd16);
        chk("stream_finc_run",   64'(finc_max), 64'd16);
        chk("stream_nwords",     64'(nwords),   64'd4);
        for (int k = 0; k < 4; k++) begin
            exp_w = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            chk("stream_word", 64'(words[k]), 64'(exp_w));
        end
        for (int k = 1; k < 4; k++) begin
            chk("stream_gap", 64'(wcycle[k] - wcycle[k-1]), 64'd4);
        end

        // Backpressure
        m_ready = 1'b0;
        for (int b = 1; b <= 8; b++) push(8'(b));
        repeat (6) tick();
        chk("bp_valid",   64'(m_valid), 64'd1);
        chk("bp_hold",    64'(m_data),  64'h04030201);
        chk("bp_f_inc",   64'(f_inc),   64'd0);
        chk("bp_left",    64'(f_empty), 64'd0);
        chk("bp_head",    64'(f_data),  64'h08);
        tick();
        chk("bp_stable",  64'(m_data),  64'h04030201);
        m_ready = 1'b1;
        tick();
        chk("bp_w2_valid", 64'(m_valid), 64'd1);
        chk("bp_w2_data",  64'(m_data),  64'h08070605);
        chk("bp_w2_count", 64'(m_count), 64'd4);
        chk("bp_drained",  64'(f_empty), 64'd1);
        tick();
        chk("bp_done", 64'(m_valid), 64'd0);

        // Flush of a partial word
        push(8'hAA); push(8'hBB);
        repeat (4) tick();
        chk("fl_no_word", 64'(m_valid), 64'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_latency", 64'(m_valid), 64'd0);
        tick();
        chk("fl_valid", 64'(m_valid), 64'd1);
        chk("fl_data",  64'(m_data),  64'h0000BBAA);
        chk("fl_count", 64'(m_count), 64'd2);
        tick();
        chk("fl_one_cycle", 64'(m_valid), 64'd0);

        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_valid("fl_next_valid", 10);
        chk("fl_next_data",  64'(m_data),  64'h04030201);
        chk("fl_next_count", 64'(m_count), 64'd4);
        tick();

        // Flush with nothing accumulated
        flush = 1'b1;
        tick();
        flush = 1'b0;
        quiet = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (!m_valid) quiet++;
        end
        chk("fl_empty_quiet", 64'(quiet), 64'd4);

        // Reset with three lanes filled
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (4) tick();
        chk("mr_pre", 64'(m_valid), 64'd0);
        rst_n = 1'b0;
        push(8'hB0); push(8'hB1); push(8'hB2); push(8'hB3);
        chk("mr_f_inc",  64'(f_inc),   64'd0);
        chk("mr_valid",  64'(m_valid), 64'd0);
        chk("mr_fifo",   64'(f_empty), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("mr_after", 64'(m_valid), 64'd0);
        wait_valid("mr_word_valid", 10);
        chk("mr_word_data",  64'(m_data),  64'hB3B2B1B0);
        chk("mr_word_count", 64'(m_count), 64'd4);
        tick();
        chk("mr_done", 64'(m_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fifo_word_packer.md
# fifo_word_packer

Downstream consumer of the synchronous FIFO's first-word-fall-through read port. Pops bytes from the FIFO and packs BYTES consecutive bytes, little-endian, into one word. Presents each word on a valid/ready output with a byte count. A flush request emits a partially filled word, so frame tails are never stranded.

## Interface
- DATA_WIDTH, 8: width of one FIFO entry ("byte").
- BYTES, 4: bytes per output word; must be ≥2.
- CW, $clog2(BYTES+1): width of m_count (localparam).

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- f_empty  in  1  FIFO read-side empty.
- f_data  in  DATA_WIDTH  FIFO head entry; valid whenever f_empty=0.
- f_inc  out  1  FIFO pop strobe; combinational.
- flush  in  1  level request to emit the current partial word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accepts when m_valid && m_ready.
- m_data  out  DATA_WIDTH*BYTES  packed word; byte k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- m_count  out  CW  number of valid bytes in m_data, 1..BYTES.

## Operation
- State held in registers:
  - acc: accumulator of BYTES lanes.
  - idx: 0..BYTES-1, next lane to fill.
  - flush_pending: flag.
  - Output register: m_valid, m_data, m_count.
- out_free = !m_valid || m_ready.
- f_inc = rst_n && !f_empty && !flush_pending && !(idx==BYTES-1 && !out_free).
- On each pop:
  - f_data is written to acc lane idx.
  - If idx < BYTES-1, idx increments.
  - If idx == BYTES-1, the completed word (acc with the new byte in the top lane) loads into the output register with m_count=BYTES, and idx and acc reset to 0.
- Flush:
  - flush=1 sets flush_pending. Setting is level-sensitive; holding flush re-arms it.
  - While flush_pending=1, no pops occur.
  - If idx==0, flush_pending clears on the next edge and nothing is emitted.
  - If idx>0 and out_free=1, the partial word loads into the output register with m_count=idx. Unused lanes are 0. idx and acc reset to 0 and flush_pending clears.
  - If idx>0 and out_free=0, the flush waits until out_free=1.
- Output handshake:
  - m_valid drops after acceptance unless a new word loads in the same cycle.
  - Accept and load in the same cycle is legal and gives back-to-back words.
  - m_data and m_count are stable while m_valid && !m_ready.
- No bytes are lost or duplicated under any m_ready pattern.

## Timing
- Reset (async assert, sync-to-clk deassert by system): m_valid=0, m_data=0, m_count=0, idx=0, acc=0, flush_pending=0. f_inc=0 while rst_n=0.
- A mid-word reset discards the partial word. FIFO contents are the FIFO's own concern.
- Latency: the final byte pops at edge N; m_valid=1 after edge N.
- Throughput: one byte per cycle with m_ready=1 and data available, giving one word every BYTES cycles with no bubbles.
- Backpressure:
  - With the output word stalled, the accumulator still fills lanes 0..BYTES-2.
  - Popping lane BYTES-1 waits for out_free.
- Flush latency: flush high at edge N sets the flag, and the partial word is valid after edge N+1 if out_free. The cycle in which flush is first seen may still pop a byte, because f_inc uses the registered flag.
- Flush and pop priority: when flush_pending=1, the flush is served before any further pops.
- Wrap-around: idx returns to 0 after lane BYTES-1 or after a flush emit.

## Structure
- No shared package needed. CW and the lane-index width are local parameters.
- Single module with no sub-modules. The output stage is inline registers.
- The bench instantiates sync_fifo (same DATA_WIDTH, ADDR_SIZE=4) feeding this block: r_empty→f_empty, r_data→f_data, f_inc→r_inc.

## Test plan
Configuration: DATA_WIDTH=8, BYTES=4.
- Post-reset: m_valid=0, m_count=0, m_data=0, f_inc=0 with FIFO empty.
- Write bytes 11,22,33,44 with m_ready=1 → one word with m_data=32'h44332211, m_count=4, m_valid high for exactly one cycle; FIFO empty afterward.
- Streaming: 16 bytes 00..0F, m_ready=1 → f_inc high for 16 consecutive cycles; words 03020100, 07060504, 0B0A0908, 0F0E0D0C back-to-back.
- Backpressure: write 01..08 with m_ready=0 → m_data held at 32'h04030201, f_inc drops with one byte (08) left in the FIFO; then m_ready=1 → 04030201 followed by 08070605, with no loss.
- Flush:
  - Bytes AA,BB then a one-cycle flush → m_data=32'h0000BBAA, m_count=2.
  - Subsequent 01..04 → 32'h04030201.
  - A flush with idx=0 emits nothing.
- Reset mid-word: 3 bytes popped, then rst_n pulsed low → m_valid stays 0; the next 4 bytes form a clean word starting at lane 0.
